// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, D = A - B - BI, LSB first, one bit per clock.
//
// A single full-subtractor cell and a borrow flop walk the operands over WIDTH
// cycles. The operation is accepted on a rising edge where busy is low. The
// result appears with a one-cycle done pulse WIDTH clocks after that edge.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   start - begin a subtraction (ignored while busy)
//   A, B  - minuend / subtrahend, sampled on the accepting edge
//   BI    - borrow-in, sampled on the accepting edge
//   busy  - operation in progress
//   done  - one-cycle pulse, D and BO newly updated
//   D     - registered difference, held until the next completion
//   BO    - registered borrow-out, held until the next completion

module serial_sub #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BI,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             BO
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             br_q, br_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bo_q, bo_d;
   logic             done_q, done_d;

   // Full-subtractor cell on the current LSBs
   logic d_bit;
   logic br_next;

   always_comb begin
      d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
      br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
   end

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bo_d    = bo_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sa_d    = A;
               sb_d    = B;
               br_d    = BI;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            // New bit enters at the MSB; after WIDTH shifts bit 0 sits at sr[0]
            sr_d  = {d_bit, sr_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               // Load the full result including the bit produced on this edge
               diff_d  = {d_bit, sr_q[WIDTH-1:1]};
               bo_d    = br_next;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bo_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sr_q    <= sr_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bo_q    <= bo_d;
         done_q  <= done_d;
      end
   end

   // All outputs come straight from flops
   assign busy = (state_q == StRun);
   assign done = done_q;
   assign D    = diff_q;
   assign BO   = bo_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub (WIDTH = 3).
// Expected results are queued when an operation is launched and compared
// when done pulses.

module tb_serial_sub;

   localparam int unsigned W = 3;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bi;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bo;

   serial_sub #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (a),
      .B    (b),
      .BI   (bi),
      .busy (busy),
      .done (done),
      .D    (d),
      .BO   (bo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      logic [W-1:0] d;
      logic         bo;
   } vec_t;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
   } exp_t;

   exp_t sb[$];
   int   checks     = 0;
   int   errors     = 0;
   int   done_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: compare every done pulse against the oldest queued result
   always begin
      @(posedge clk);
      #1;
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_D", int'(d), int'(e.d));
            chk("result_BO", int'(bo), int'(e.bo));
         end
         done_count++;
      end
   end

   task automatic push_exp(input logic [W-1:0] ed, input logic ebo);
      exp_t e;
      e.d  = ed;
      e.bo = ebo;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_count < target && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (done_count < target) chk("done_timeout", done_count, target);
   endtask

   // Launch one operation at a negedge where busy is low
   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibi,
                        input logic [W-1:0] ed, input logic ebo);
      wait_idle();
      start = 1'b1;
      a     = ia;
      b     = ib;
      bi    = ibi;
      push_exp(ed, ebo);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
   endtask

   vec_t tbl[8];

   initial begin
      int base;
      int n;

      tbl[0] = '{a: 3'd5, b: 3'd3, bi: 1'b0, d: 3'd2, bo: 1'b0};
      tbl[1] = '{a: 3'd3, b: 3'd5, bi: 1'b0, d: 3'd6, bo: 1'b1};
      tbl[2] = '{a: 3'd0, b: 3'd0, bi: 1'b1, d: 3'd7, bo: 1'b1};
      tbl[3] = '{a: 3'd7, b: 3'd7, bi: 1'b0, d: 3'd0, bo: 1'b0};
      tbl[4] = '{a: 3'd6, b: 3'd1, bi: 1'b0, d: 3'd5, bo: 1'b0};
      tbl[5] = '{a: 3'd4, b: 3'd1, bi: 1'b0, d: 3'd3, bo: 1'b0};
      tbl[6] = '{a: 3'd2, b: 3'd3, bi: 1'b0, d: 3'd7, bo: 1'b1};
      tbl[7] = '{a: 3'd1, b: 3'd1, bi: 1'b0, d: 3'd0, bo: 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bi    = 1'b0;
      #12;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_D", int'(d), 0);
      chk("reset_BO", int'(bo), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Latency: busy for WIDTH cycles, done in the cycle after
      start = 1'b1;
      a     = tbl[0].a;
      b     = tbl[0].b;
      bi    = tbl[0].bi;
      push_exp(tbl[0].d, tbl[0].bo);
      for (int k = 1; k <= int'(W); k++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("lat_busy_%0d", k), int'(busy), 1);
         chk($sformatf("lat_done_%0d", k), int'(done), 0);
      end
      @(negedge clk);
      chk("lat_done_pulse", int'(done), 1);
      chk("lat_busy_clear", int'(busy), 0);

      // Directed table vectors
      for (int i = 1; i <= 3; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].bi, tbl[i].d, tbl[i].bo);
      end
      wait_done(4);

      // start during busy is ignored
      wait_idle();
      base  = done_count;
      start = 1'b1;
      a     = tbl[4].a;
      b     = tbl[4].b;
      bi    = tbl[4].bi;
      push_exp(tbl[4].d, tbl[4].bo);
      @(negedge clk);
      chk("ign_busy", int'(busy), 1);
      a = 3'd0;
      b = 3'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(base + 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("ign_D_hold", int'(d), 5);
      end

      // start held high: next op accepted in the done cycle
      wait_idle();
      base  = done_count;
      start = 1'b1;
      a     = tbl[5].a;
      b     = tbl[5].b;
      bi    = tbl[5].bi;
      push_exp(tbl[5].d, tbl[5].bo);
      @(negedge clk);
      chk("held_busy", int'(busy), 1);
      a = tbl[6].a;
      b = tbl[6].b;
      push_exp(tbl[6].d, tbl[6].bo);
      wait_done(base + 1);
      chk("held_done", int'(done), 1);
      @(negedge clk);
      chk("held_reaccept", int'(busy), 1);
      start = 1'b0;
      wait_done(base + 2);

      // Asynchronous reset aborts an operation in flight
      wait_idle();
      start = 1'b1;
      a     = 3'd6;
      b     = 3'd2;
      bi    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_D", int'(d), 0);
      chk("abort_BO", int'(bo), 0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      chk("abort_idle", int'(busy), 0);
      do_op(tbl[7].a, tbl[7].b, tbl[7].bi, tbl[7].d, tbl[7].bo);

      // Exhaustive sweep against an arithmetic reference
      for (int ia = 0; ia < 8; ia++) begin
         for (int ib = 0; ib < 8; ib++) begin
            for (int ibi = 0; ibi < 2; ibi++) begin
               int diff;
               diff = (ia - ib - ibi) & 7;
               do_op(W'(ia), W'(ib), ibi[0], W'(diff), (ia < ib + ibi));
            end
         end
      end

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
